memory_port_arbiter: RTL and testbench
======================================

// Module: memory_port_arbiter
// PURPOSE
//   Shares the single memory port between two bus masters: m0 is the core,
//   m1 is a secondary master such as a loader, debug or DMA engine.
//   Runs one transaction at a time through an IDLE/ISSUE/WAIT/DONE FSM.
//   Uses round-robin arbitration and a fixed, parameterised memory read latency.
//   Sits between the masters and the memory model; its memory-side ports connect straight to memory.
// PARAMETERS
//   ADDR_WIDTH   32  width of all address buses
//   DATA_WIDTH   32  width of all data buses
//   MEM_LATENCY  1   cycles from address presented to memory_data_in valid; legal range 0..15
// PORTS
//   clk                  in   1           system clock; all state updates on its rising edge
//   reset                in   1           asynchronous, active-high reset
//   m0_req / m1_req      in   1           request; held high until the matching ack
//   m0_write / m1_write  in   1           1 = write, 0 = read; stable while req is high
//   m0_address/m1_address in  ADDR_WIDTH  transaction address; stable while req is high
//   m0_wdata / m1_wdata  in   DATA_WIDTH  write data; stable while req is high
//   m0_gnt / m1_gnt      out  1           master owns the port (ISSUE, WAIT and DONE states)
//   m0_ack / m1_ack      out  1           one-cycle completion pulse
//   m0_rdata / m1_rdata  out  DATA_WIDTH  read data; valid in the ack cycle of a read
//   memory_address       out  ADDR_WIDTH  to memory
//   memory_data_out      out  DATA_WIDTH  write data to memory
//   memory_write_enable  out  1           write strobe to memory
//   memory_data_in       in   DATA_WIDTH  read data from memory
//   busy                 out  1           FSM is not in IDLE
// BEHAVIOUR
//   Reset (async, any state): FSM=IDLE, counter=0, last_grant=m1 (so m0 wins the first tie).
//     - All gnt/ack, memory_write_enable and busy are 0.
//     - memory_address, memory_data_out and both rdata registers are 0.
//     - Reset asserted mid-transaction aborts it with no ack.
//   IDLE: memory bus driven to 0 and write enable 0.
//     - Only one master has req=1: that master is granted.
//     - Both have req=1: the master not in last_grant is granted.
//     - Any grant: latch master select into sel, set last_grant=sel, go to ISSUE.
//   ISSUE (cycle N):
//     - memory_address/memory_data_out = address/wdata of the selected master.
//     - memory_write_enable = that master's write bit, this cycle only.
//     - Counter loads MEM_LATENCY.
//     - Write, or MEM_LATENCY==0: go to DONE. Otherwise go to WAIT.
//   WAIT: address stays driven, write enable 0, counter decrements each cycle.
//     - When counter reaches 1, go to DONE.
//   Read capture: sel's rdata register samples memory_data_in at the end of cycle N+MEM_LATENCY.
//   DONE (cycle N+1 for writes, N+MEM_LATENCY+1 for reads):
//     - Selected master's ack=1; its rdata is valid for a read.
//     - Go to IDLE; gnt drops with the state change.
//   Masters drop req in the cycle after ack; req still high in IDLE is treated as a new request.
//   The non-selected master's rdata holds its value; writes never modify rdata.
//   Request inputs are ignored outside IDLE; no preemption.
//   Throughput: one transaction per MEM_LATENCY+3 cycles for reads, 3 cycles for writes.
//   gnt, ack, busy and memory_write_enable are one-hot per master and never high for both masters.
// TESTING
//   1. m0 read of 0x100, MEM_LATENCY=1, memory returns 0xDEADBEEF:
//      -> memory_address=0x100 in cycles N and N+1; m0_ack in N+2 with m0_rdata=0xDEADBEEF.
//   2. m1 write of 0x55AA to 0x40:
//      -> memory_write_enable high in cycle N only with data 0x55AA; m1_ack in N+1; m1_rdata unchanged.
//   3. m0_req and m1_req both high continuously, each dropping req for one cycle after its ack:
//      -> grants alternate m0, m1, m0, m1; never both gnt high at once.
//   4. MEM_LATENCY=3 read:
//      -> ack exactly 4 cycles after ISSUE; memory_address stable throughout.
//   5. Assert reset during WAIT:
//      -> all outputs 0 asynchronously; no ack; after release m0 wins a tie.
//   6. MEM_LATENCY=0 read: memory_data_in sampled in cycle N -> ack in N+1.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// Two-master memory port arbiter: round-robin grant, one transaction at a time,
// with a fixed memory read latency counted down between issue and completion.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic                  m0_write,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_ack,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0] memory_data_out,
  output logic                  memory_write_enable,
  input  logic [DATA_WIDTH-1:0] memory_data_in,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT      = 4'(MEM_LATENCY);
  localparam bit         ZERO_LAT = (MEM_LATENCY == 0);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  sel_q;
  logic                  last_q;
  logic                  write_q;
  logic                  m0_gnt_q, m1_gnt_q;
  logic                  m0_ack_q, m1_ack_q;
  logic                  busy_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

  logic                  sel_d;
  logic                  start_d;
  logic                  write_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // m0 takes the port unless m1 is the sole requester or it is m1's turn
  assign sel_d   = m1_req & (~m0_req | ~last_q);
  assign start_d = m0_req | m1_req;
  assign write_d = sel_d ? m1_write   : m0_write;
  assign addr_d  = sel_d ? m1_address : m0_address;
  assign wdata_d = sel_d ? m1_wdata   : m0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      write_q     <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            sel_q       <= sel_d;
            last_q      <= sel_d;
            write_q     <= write_d;
            m0_gnt_q    <= ~sel_d;
            m1_gnt_q    <= sel_d;
            busy_q      <= 1'b1;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            mem_we_q    <= write_d;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_we_q <= 1'b0;
          cnt_q    <= LAT;
          if (write_q || ZERO_LAT) begin
            state_q  <= S_DONE;
            m0_ack_q <= ~sel_q;
            m1_ack_q <= sel_q;
            // zero-latency reads capture in the issue cycle itself
            if (!write_q) begin
              if (sel_q) m1_rdata_q <= memory_data_in;
              else       m0_rdata_q <= memory_data_in;
            end
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_q  <= S_DONE;
            m0_ack_q <= ~sel_q;
            m1_ack_q <= sel_q;
            if (sel_q) m1_rdata_q <= memory_data_in;
            else       m0_rdata_q <= memory_data_in;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          m0_gnt_q    <= 1'b0;
          m1_gnt_q    <= 1'b0;
          busy_q      <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m0_gnt              = m0_gnt_q;
  assign m1_gnt              = m1_gnt_q;
  assign m0_ack              = m0_ack_q;
  assign m1_ack              = m1_ack_q;
  assign m0_rdata            = m0_rdata_q;
  assign m1_rdata            = m1_rdata_q;
  assign memory_address      = mem_addr_q;
  assign memory_data_out     = mem_wdata_q;
  assign memory_write_enable = mem_we_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: three instances (latency 0, 1, 3), each with its own
// latency-accurate memory model, random masters and a transaction-level reference model.
module tb_memory_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done [3] = '{1'b0, 1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5A0F0F) + 32'h01234567);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int LAT = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);

    logic        rst = 1'b1;
    logic [1:0]  req, wr, gnt, ack;
    logic [31:0] addr [2];
    logic [31:0] wd [2];
    logic [31:0] rdata [2];
    logic [31:0] maddr, mdout, mdin;
    logic        mwe, bsy;
    logic [31:0] ah [1:15];

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(rst),
      .m0_req(req[0]), .m1_req(req[1]),
      .m0_write(wr[0]), .m1_write(wr[1]),
      .m0_address(addr[0]), .m1_address(addr[1]),
      .m0_wdata(wd[0]), .m1_wdata(wd[1]),
      .m0_gnt(gnt[0]), .m1_gnt(gnt[1]),
      .m0_ack(ack[0]), .m1_ack(ack[1]),
      .m0_rdata(rdata[0]), .m1_rdata(rdata[1]),
      .memory_address(maddr), .memory_data_out(mdout),
      .memory_write_enable(mwe), .memory_data_in(mdin),
      .busy(bsy)
    );

    // Memory: data for the address presented LAT cycles ago
    always @(posedge clk) begin
      ah[1] <= maddr;
      for (int k = 2; k <= 15; k++) ah[k] <= ah[k-1];
    end
    if (LAT == 0) begin : zl
      assign mdin = memval(maddr);
    end else begin : nl
      assign mdin = memval(ah[LAT]);
    end

    // Reference model: one transaction occupies cycles t0..te, te being the ack cycle
    int          cyc = 0;
    bit          mb = 1'b0, ms = 1'b0, mw = 1'b0, lastg = 1'b1;
    logic [31:0] ma = '0, mwd = '0;
    int          t0 = 0, te = 0;
    logic [31:0] er [2] = '{32'h0, 32'h0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
      logic [1:0] eg, ea;
      logic       ewe;
      eg = 2'b00; ea = 2'b00; ewe = 1'b0;
      if (rst) begin
        mb = 1'b0; lastg = 1'b1; er[0] = '0; er[1] = '0;
      end else if (mb && cyc > te) begin
        mb = 1'b0;
      end
      if (mb) begin
        eg[ms] = 1'b1;
        ea[ms] = (cyc == te);
        ewe    = mw && (cyc == t0);
        if (cyc == te && !mw) er[ms] = memval(ma);
      end
      chk($sformatf("L%0d gnt", LAT), 32'(gnt), 32'(eg));
      chk($sformatf("L%0d ack", LAT), 32'(ack), 32'(ea));
      chk($sformatf("L%0d busy", LAT), 32'(bsy), 32'(mb));
      chk($sformatf("L%0d we", LAT), 32'(mwe), 32'(ewe));
      chk($sformatf("L%0d rdata0", LAT), rdata[0], er[0]);
      chk($sformatf("L%0d rdata1", LAT), rdata[1], er[1]);
      if (!mb) begin
        chk($sformatf("L%0d idle addr", LAT), maddr, 32'h0);
        chk($sformatf("L%0d idle dout", LAT), mdout, 32'h0);
      end else begin
        if (cyc < te)  chk($sformatf("L%0d addr", LAT), maddr, ma);
        if (cyc == t0) chk($sformatf("L%0d dout", LAT), mdout, mwd);
      end
      if (!rst && !mb && req != 2'b00) begin
        ms    = req[1] && (!req[0] || !lastg);
        lastg = ms;
        mw    = wr[ms];
        ma    = addr[ms];
        mwd   = wd[ms];
        t0    = cyc + 1;
        te    = t0 + ((mw || LAT == 0) ? 1 : LAT + 1);
        mb    = 1'b1;
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    // Masters: drop req the cycle after ack, raise new random requests with probability pct
    task automatic run_masters(input int ncyc, input int pct, input bit alt);
      logic [1:0] ak;
      int         prev;
      prev = -1;
      for (int k = 0; k < ncyc; k++) begin
        @(negedge clk);
        ak = ack;
        if (alt) begin
          for (int m = 0; m < 2; m++) begin
            if (ak[m]) begin
              if (prev >= 0) chk($sformatf("L%0d alternate", LAT), 32'(m), 32'(1 - prev));
              prev = m;
            end
          end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
          if (req[m] && ak[m]) begin
            req[m] = 1'b0;
          end else if (!req[m] && $urandom_range(0, 99) < pct) begin
            req[m]  = 1'b1;
            wr[m]   = 1'($urandom_range(0, 1));
            addr[m] = $urandom;
            wd[m]   = $urandom;
          end
        end
      end
    endtask

    initial begin
      req = 2'b00; wr = 2'b00;
      addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("L%0d reset gnt", LAT), 32'(gnt), 32'h0);
      chk($sformatf("L%0d reset busy", LAT), 32'(bsy), 32'h0);
      chk($sformatf("L%0d reset addr", LAT), maddr, 32'h0);
      chk($sformatf("L%0d reset rdata0", LAT), rdata[0], 32'h0);
      rst = 1'b0;

      // m0 read of 0x100
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h100; wd[0] = 32'h0BADF00D;
      step();
      chk($sformatf("L%0d rd issue gnt", LAT), 32'(gnt), 32'h1);
      chk($sformatf("L%0d rd issue addr", LAT), maddr, 32'h100);
      chk($sformatf("L%0d rd issue we", LAT), 32'(mwe), 32'h0);
      for (int k = 1; k <= LAT; k++) begin
        step();
        chk($sformatf("L%0d rd wait addr", LAT), maddr, 32'h100);
        chk($sformatf("L%0d rd wait ack", LAT), 32'(ack), 32'h0);
      end
      step();
      chk($sformatf("L%0d rd ack", LAT), 32'(ack), 32'h1);
      chk($sformatf("L%0d rd data", LAT), rdata[0], 32'hDEADBEEF);
      step();
      req[0] = 1'b0;
      chk($sformatf("L%0d rd after", LAT), {29'h0, bsy, gnt}, 32'h0);

      // m1 write of 0x55AA to 0x40
      req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h40; wd[1] = 32'h55AA;
      step();
      chk($sformatf("L%0d wr we", LAT), 32'(mwe), 32'h1);
      chk($sformatf("L%0d wr dout", LAT), mdout, 32'h55AA);
      chk($sformatf("L%0d wr addr", LAT), maddr, 32'h40);
      chk($sformatf("L%0d wr gnt", LAT), 32'(gnt), 32'h2);
      step();
      chk($sformatf("L%0d wr we off", LAT), 32'(mwe), 32'h0);
      chk($sformatf("L%0d wr ack", LAT), 32'(ack), 32'h2);
      chk($sformatf("L%0d wr rdata1", LAT), rdata[1], 32'h0);
      step();
      req[1] = 1'b0;

      run_masters(60, 100, 1'b1);
      run_masters(400, 30, 1'b0);
      run_masters(30, 0, 1'b0);

      // Reset in the middle of a read from m1
      req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h00000ABC;
      step();
      if (LAT > 0) step();
      #1;
      rst = 1'b1;
      #1;
      chk($sformatf("L%0d async gnt", LAT), 32'(gnt), 32'h0);
      chk($sformatf("L%0d async busy", LAT), 32'(bsy), 32'h0);
      chk($sformatf("L%0d async addr", LAT), maddr, 32'h0);
      chk($sformatf("L%0d async dout", LAT), mdout, 32'h0);
      chk($sformatf("L%0d async rdata0", LAT), rdata[0], 32'h0);
      chk($sformatf("L%0d async rdata1", LAT), rdata[1], 32'h0);
      step();
      chk($sformatf("L%0d no ack in reset", LAT), 32'(ack), 32'h0);
      rst = 1'b0;
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = $urandom;
      step();
      chk($sformatf("L%0d tie after reset", LAT), 32'(gnt), 32'h1);
      run_masters(20, 0, 1'b0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      checks++;
      errors++;
      $display("FAIL timeout: got unfinished instances, expected all done");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
